seq_mul_rec: RTL



---
 rtl/seq_mul_rec_pkg.sv | 19 +
 rtl/seq_mul_rec_approx_add16.sv | 36 +++
 rtl/seq_mul_rec.sv | 88 ++++++++
 3 files changed

// File: rtl/seq_mul_rec_pkg.sv
// Shared definitions for the seq_mul_rec shift-add reconstructor.
// Holds operand/result widths, FSM state encoding and the approximate adder cell.
package seq_mul_rec_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sum bit of the approximate cell: it reads 1 instead of 0 when a^b=1 and cin=1.
  function automatic logic approx_sum(input logic a, input logic b, input logic cin);
    return (a ^ b) | cin;
  endfunction

endpackage

// File: rtl/seq_mul_rec_approx_add16.sv
// Combinational 16-bit ripple adder with no carry in and the carry out discarded.
// Macro APPROX_ADD_EN: the low APPROX_BITS sum bits use the approximate cell.
module approx_add16
  import seq_mul_rec_pkg::*;
#(
  parameter int APPROX_BITS = 2
) (
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] sum
);

`ifdef APPROX_ADD_EN
  localparam bit APPROX_ON = 1'b1;
`else
  localparam bit APPROX_ON = 1'b0;
`endif
  localparam int N_APPROX = APPROX_ON ? APPROX_BITS : 0;

  logic [RES_W-1:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < RES_W; i++) begin : g_bit
    if (i < N_APPROX) begin : g_apx
      assign sum[i] = approx_sum(a[i], b[i], c[i]);
    end else begin : g_exact
      assign sum[i] = a[i] ^ b[i] ^ c[i];
    end
    // The carry is always the exact majority; the carry out of the top bit is dropped.
    if (i < RES_W - 1) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

endmodule

// File: rtl/seq_mul_rec.sv
// Sequential shift-add reconstructor: p = q*y + r over 8 iterations.
// Macro APPROX_ADD_EN selects approximate cells for the low APPROX_BITS adder bits.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | 8 shift-add iterations, one per cycle
// DONE  | out_valid high, p held until out_ready
module seq_mul_rec
  import seq_mul_rec_pkg::*;
#(
  parameter int APPROX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  q,
  input  logic [OP_W-1:0]  y,
  input  logic [OP_W-1:0]  r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] p
);

  state_t           state;
  logic [OP_W-1:0]  qreg;
  logic [RES_W-1:0] mreg;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] sum;
  logic [2:0]       cnt;

  approx_add16 #(.APPROX_BITS(APPROX_BITS)) u_add (
    .a   (acc),
    .b   (mreg),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      qreg      <= '0;
      mreg      <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            qreg     <= q;
            mreg     <= {8'b0, y};
            acc      <= {8'b0, r};
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (qreg[0]) acc <= sum;
          mreg <= mreg << 1;
          qreg <= qreg >> 1;
          cnt  <= cnt + 3'd1;
          // No early exit: latency is fixed regardless of the multiplier value.
          if (cnt == 3'd7) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign p = acc;

endmodule
